// File: rtl/cavlc_pkg.sv
// cavlc_pkg
//   Shared constants and types for the CAVLC coeff_token fixed-length code
//   (nC >= 8) decode path.
//   Contents:
//     COEFF_TOKEN_FLC_LEN  codeword length in bits
//     FLC_TC0_CODE         the one codeword that means TotalCoeff = 0
//     FLC_ILL_A/FLC_ILL_B  codewords with no valid (TC, T1) meaning
//     coeff_token_t        decoded token {tc, t1, illegal}
package cavlc_pkg;

    localparam int unsigned COEFF_TOKEN_FLC_LEN = 6;

    localparam logic [5:0] FLC_TC0_CODE = 6'b000011;
    localparam logic [5:0] FLC_ILL_A    = 6'b000010;
    localparam logic [5:0] FLC_ILL_B    = 6'b000111;

    typedef struct packed {
        logic [4:0] tc;
        logic [1:0] t1;
        logic       illegal;
    } coeff_token_t;

endpackage

// File: rtl/coeff_token_flc_lut.sv
// coeff_token_flc_lut
//   Combinational decode of one 6-bit coeff_token FLC codeword.
//   Ports:
//     code  in   6-bit codeword
//     tok   out  decoded TotalCoeff / TrailingOnes / illegal flag
//   Macro COEFF_TOKEN_FLC_ERR_EN: when defined, the two unused codewords
//   are flagged illegal; otherwise illegal is always 0 and those codewords
//   decode by the generic rule.
//   tc/t1 here are always the generic-rule values; the parser zeroes them
//   for a flagged codeword when it registers the token.
module coeff_token_flc_lut
    import cavlc_pkg::*;
(
    input  logic [5:0]   code,
    output coeff_token_t tok
);

    always_comb begin
        tok = '0;
        if (code == FLC_TC0_CODE) begin
            tok.tc = '0;
            tok.t1 = '0;
        end else begin
            tok.tc = {1'b0, code[5:2]} + 5'd1;
            tok.t1 = code[1:0];
        end
`ifdef COEFF_TOKEN_FLC_ERR_EN
        tok.illegal = (code == FLC_ILL_A) || (code == FLC_ILL_B);
`else
        tok.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/coeff_token_flc_parser.sv
// coeff_token_flc_parser
//   Serial-bit decoder for the H.264 CAVLC coeff_token FLC (nC >= 8).
//   Collects 6 bits MSB first and presents TotalCoeff / TrailingOnes through
//   a one-entry registered valid/ready output stage.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     bit_valid_i, bit_i   incoming codeword bit (MSB first)
//     bit_ready_o          bit can be accepted this cycle (combinational)
//     flush_i              drop any partial codeword (held token kept)
//     tok_valid_o          token held on the outputs
//     tok_ready_i          downstream takes the token
//     total_coeff_cnt_o    TotalCoeff 0..16
//     trailing_ones_cnt_o  TrailingOnes 0..3
//     code_o               raw codeword of the held token
//     illegal_o            held codeword is illegal (COEFF_TOKEN_FLC_ERR_EN only)
//     busy_o               1..5 bits of a codeword collected
//     token_cnt_o          tokens delivered downstream (wrapping)
//   Macro COEFF_TOKEN_FLC_ERR_EN enables illegal-code flagging.
module coeff_token_flc_parser
    import cavlc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             bit_ready_o,
    input  logic             flush_i,
    output logic             tok_valid_o,
    input  logic             tok_ready_i,
    output logic [4:0]       total_coeff_cnt_o,
    output logic [1:0]       trailing_ones_cnt_o,
    output logic [5:0]       code_o,
`ifdef COEFF_TOKEN_FLC_ERR_EN
    output logic             illegal_o,
`endif
    output logic             busy_o,
    output logic [CNT_W-1:0] token_cnt_o
);

    logic [2:0]   bcnt;
    // Only the five pending bits are stored; the sixth goes straight to decode.
    logic [4:0]   sreg;
    logic [5:0]   code_d;
    coeff_token_t lut_tok;
    logic         accept;
    logic         load;
    logic         out_hs;
    logic         last_bit;

    assign last_bit = (bcnt == 3'(COEFF_TOKEN_FLC_LEN - 1));

    // Only the completing bit stalls on a held, unaccepted token.
    assign bit_ready_o = !rst && !(last_bit && tok_valid_o && !tok_ready_i);
    assign accept      = bit_valid_i && bit_ready_o;
    assign load        = accept && last_bit && !flush_i;
    assign out_hs      = tok_valid_o && tok_ready_i;
    assign code_d      = {sreg, bit_i};
    assign busy_o      = (bcnt != '0);

    coeff_token_flc_lut u_lut (
        .code (code_d),
        .tok  (lut_tok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt                <= '0;
            sreg                <= '0;
            tok_valid_o         <= 1'b0;
            total_coeff_cnt_o   <= '0;
            trailing_ones_cnt_o <= '0;
            code_o              <= '0;
`ifdef COEFF_TOKEN_FLC_ERR_EN
            illegal_o           <= 1'b0;
`endif
            token_cnt_o         <= '0;
        end else begin
            if (flush_i) begin
                bcnt <= '0;
                sreg <= '0;
            end else if (accept) begin
                if (last_bit) begin
                    bcnt <= '0;
                    sreg <= '0;
                end else begin
                    bcnt <= bcnt + 3'd1;
                    sreg <= {sreg[3:0], bit_i};
                end
            end

            // A load in the handshake cycle replaces the token with no bubble.
            if (load) begin
                tok_valid_o         <= 1'b1;
                total_coeff_cnt_o   <= lut_tok.illegal ? '0 : lut_tok.tc;
                trailing_ones_cnt_o <= lut_tok.illegal ? '0 : lut_tok.t1;
                code_o              <= code_d;
`ifdef COEFF_TOKEN_FLC_ERR_EN
                illegal_o           <= lut_tok.illegal;
`endif
            end else if (out_hs) begin
                tok_valid_o <= 1'b0;
            end

            if (out_hs) begin
                token_cnt_o <= token_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coeff_token_flc_parser.sv
module tb_coeff_token_flc_parser;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_valid_i;
    logic             bit_i;
    logic             bit_ready_o;
    logic             flush_i;
    logic             tok_valid_o;
    logic             tok_ready_i;
    logic [4:0]       total_coeff_cnt_o;
    logic [1:0]       trailing_ones_cnt_o;
    logic [5:0]       code_o;
`ifdef COEFF_TOKEN_FLC_ERR_EN
    logic             illegal_o;
`endif
    logic             busy_o;
    logic [CNT_W-1:0] token_cnt_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    coeff_token_flc_parser #(.CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bit_valid_i         (bit_valid_i),
        .bit_i               (bit_i),
        .bit_ready_o         (bit_ready_o),
        .flush_i             (flush_i),
        .tok_valid_o         (tok_valid_o),
        .tok_ready_i         (tok_ready_i),
        .total_coeff_cnt_o   (total_coeff_cnt_o),
        .trailing_ones_cnt_o (trailing_ones_cnt_o),
        .code_o              (code_o),
`ifdef COEFF_TOKEN_FLC_ERR_EN
        .illegal_o           (illegal_o),
`endif
        .busy_o              (busy_o),
        .token_cnt_o         (token_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_tok(input string tag, input logic [4:0] tc, input logic [1:0] t1,
                             input logic [5:0] code);
        check({tag, "_valid"}, 32'(tok_valid_o), 32'd1);
        check({tag, "_tc"}, 32'(total_coeff_cnt_o), 32'(tc));
        check({tag, "_t1"}, 32'(trailing_ones_cnt_o), 32'(t1));
        check({tag, "_code"}, 32'(code_o), 32'(code));
    endtask

    // Drive one bit per cycle for the given number of leading bits of code.
    task automatic feed(input string tag, input logic [5:0] code, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) begin
            bit_valid_i = 1'b1;
            bit_i       = code[5-i];
            #1;
            check({tag, "_rdy"}, 32'(bit_ready_o), 32'd1);
            step();
        end
        bit_valid_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
        flush_i     = 1'b0;
        tok_ready_i = 1'b1;
        step();
        step();
        check("rst_rdy", 32'(bit_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rdy_after", 32'(bit_ready_o), 32'd1);
        check("rst_valid", 32'(tok_valid_o), 32'd0);
        check("rst_tc", 32'(total_coeff_cnt_o), 32'd0);
        check("rst_t1", 32'(trailing_ones_cnt_o), 32'd0);
        check("rst_code", 32'(code_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cnt", 32'(token_cnt_o), 32'd0);

        // TotalCoeff = 0 codeword
        feed("t0", 6'b000011, 1);
        check("t0_busy", 32'(busy_o), 32'd1);
        feed("t0", 6'b000011 << 1, 5);
        check_tok("t0", 5'd0, 2'd0, 6'b000011);
        check("t0_cnt_pre", 32'(token_cnt_o), 32'd0);
        check("t0_busy_end", 32'(busy_o), 32'd0);
        step();
        check("t0_drained", 32'(tok_valid_o), 32'd0);
        check("t0_cnt", 32'(token_cnt_o), 32'd1);

        // back-to-back: max TC then a mid-table code
        feed("b2b_a", 6'b111111, 6);
        check_tok("b2b_a", 5'd16, 2'd3, 6'b111111);
        feed("b2b_b", 6'b010110, 6);
        check_tok("b2b_b", 5'd6, 2'd2, 6'b010110);
        check("b2b_cnt_mid", 32'(token_cnt_o), 32'd2);
        step();
        check("b2b_cnt", 32'(token_cnt_o), 32'd3);

        // backpressure: hold a token, next codeword's last bit stalls
        tok_ready_i = 1'b0;
        feed("bp_a", 6'b000100, 6);
        check_tok("bp_a", 5'd2, 2'd0, 6'b000100);
        feed("bp_b", 6'b001001, 5);
        check_tok("bp_hold", 5'd2, 2'd0, 6'b000100);
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        #1;
        check("bp_stall_rdy", 32'(bit_ready_o), 32'd0);
        step();
        check("bp_stall_busy", 32'(busy_o), 32'd1);
        check_tok("bp_stall", 5'd2, 2'd0, 6'b000100);
        tok_ready_i = 1'b1;
        #1;
        check("bp_release_rdy", 32'(bit_ready_o), 32'd1);
        step();
        bit_valid_i = 1'b0;
        check_tok("bp_b", 5'd3, 2'd1, 6'b001001);
        check("bp_cnt_mid", 32'(token_cnt_o), 32'd4);
        check("bp_busy", 32'(busy_o), 32'd0);
        step();
        check("bp_cnt", 32'(token_cnt_o), 32'd5);
        check("bp_drained", 32'(tok_valid_o), 32'd0);

        // flush with the 4th bit, then a clean codeword
        feed("fl", 6'b111000, 3);
        check("fl_busy_pre", 32'(busy_o), 32'd1);
        flush_i     = 1'b1;
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        step();
        flush_i     = 1'b0;
        bit_valid_i = 1'b0;
        check("fl_busy", 32'(busy_o), 32'd0);
        check("fl_novalid", 32'(tok_valid_o), 32'd0);
        feed("fl_ok", 6'b000001, 6);
        check_tok("fl_ok", 5'd1, 2'd1, 6'b000001);
        step();
        check("fl_cnt", 32'(token_cnt_o), 32'd6);

        // flush coinciding with a sixth bit discards it
        feed("fl6", 6'b101010, 5);
        flush_i     = 1'b1;
        bit_valid_i = 1'b1;
        bit_i       = 1'b0;
        step();
        flush_i     = 1'b0;
        bit_valid_i = 1'b0;
        check("fl6_novalid", 32'(tok_valid_o), 32'd0);
        check("fl6_busy", 32'(busy_o), 32'd0);
        check("fl6_code", 32'(code_o), 32'h01);

        // illegal codewords
        feed("ill_a", 6'b000010, 6);
`ifdef COEFF_TOKEN_FLC_ERR_EN
        check_tok("ill_a", 5'd0, 2'd0, 6'b000010);
        check("ill_a_flag", 32'(illegal_o), 32'd1);
`else
        check_tok("ill_a", 5'd1, 2'd2, 6'b000010);
`endif
        feed("ill_b", 6'b000111, 6);
`ifdef COEFF_TOKEN_FLC_ERR_EN
        check_tok("ill_b", 5'd0, 2'd0, 6'b000111);
        check("ill_b_flag", 32'(illegal_o), 32'd1);
`else
        check_tok("ill_b", 5'd2, 2'd3, 6'b000111);
`endif
        step();
        check("ill_cnt", 32'(token_cnt_o), 32'd8);

        // counter wrap (4-bit counter in this bench)
        for (int unsigned k = 0; k < 7; k++) begin
            feed("wrap_fill", 6'b000000, 6);
            step();
        end
        check("wrap_full", 32'(token_cnt_o), 32'd15);
        feed("wrap_last", 6'b110100, 6);
        check_tok("wrap_last", 5'd14, 2'd0, 6'b110100);
        step();
        check("wrap_zero", 32'(token_cnt_o), 32'd0);

        // reset mid-codeword with a held token
        tok_ready_i = 1'b0;
        feed("mr", 6'b110000, 6);
        check_tok("mr_held", 5'd13, 2'd0, 6'b110000);
        feed("mr_part", 6'b101000, 3);
        rst = 1'b1;
        #1;
        check("mr_rdy_rst", 32'(bit_ready_o), 32'd0);
        step();
        rst = 1'b0;
        tok_ready_i = 1'b1;
        #1;
        check("mr_rdy", 32'(bit_ready_o), 32'd1);
        check("mr_valid", 32'(tok_valid_o), 32'd0);
        check("mr_tc", 32'(total_coeff_cnt_o), 32'd0);
        check("mr_t1", 32'(trailing_ones_cnt_o), 32'd0);
        check("mr_code", 32'(code_o), 32'd0);
        check("mr_busy", 32'(busy_o), 32'd0);
        check("mr_cnt", 32'(token_cnt_o), 32'd0);
`ifdef COEFF_TOKEN_FLC_ERR_EN
        check("mr_ill", 32'(illegal_o), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
